// File: rtl/top_level_pkg.sv
// Shared types, memory map and Hamming(16,11) SECDED helpers for the top_level accelerator.
package top_level_pkg;

  typedef enum logic [1:0] {PROG1, PROG2, PROG3} prog_e;

  typedef enum logic [2:0] {
    S_IDLE, S_WORD, S_PAT, S_SCAN, S_W0, S_W1, S_W2, S_CYC
  } state_e;

  localparam logic [7:0] P1_IN   = 8'd0;
  localparam logic [7:0] P1_OUT  = 8'd30;
  localparam logic [7:0] P2_IN   = 8'd64;
  localparam logic [7:0] P2_OUT  = 8'd94;
  localparam logic [7:0] P3_STR  = 8'd128;
  localparam logic [7:0] P3_PAT  = 8'd160;
  localparam logic [7:0] P3_OUT  = 8'd192;
  localparam logic [7:0] CYC_OUT = 8'd195;

  localparam int WORDS     = 15;
  localparam int STR_BYTES = 32;

  // d[0] is d1 ... d[10] is d11; codeword bit index equals Hamming position.
  function automatic logic [15:0] hamming_encode(input logic [10:0] d);
    logic [15:0] c;
    c       = '0;
    c[3]    = d[0];
    c[7:5]  = d[3:1];
    c[15:9] = d[10:4];
    c[1]    = d[10] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
    c[2]    = d[10] ^ d[9] ^ d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    c[4]    = d[10] ^ d[9] ^ d[8] ^ d[7] ^ d[3] ^ d[2] ^ d[1];
    c[8]    = ^d[10:4];
    c[0]    = ^c[15:1];
    return c;
  endfunction

  // Returns {P, S}: overall parity and XOR of the positions of set bits 1..15.
  function automatic logic [4:0] hamming_syndrome(input logic [15:0] c);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i < 16; i++) begin
      if (c[i]) s = s ^ 4'(i);
    end
    return {^c, s};
  endfunction

  // Returns {hi_byte, lo_byte} as stored by the decode program.
  function automatic logic [15:0] hamming_decode(input logic [15:0] c);
    logic [4:0]  syn;
    logic [10:0] d;
    logic        dbl;
    syn = hamming_syndrome(c);
    d   = {c[15:9], c[7:5], c[3]};
    dbl = 1'b0;
    if (syn[4]) begin
      // Only flips landing on data positions change the extracted data.
      case (syn[3:0])
        4'd3:    d[0]  = ~d[0];
        4'd5:    d[1]  = ~d[1];
        4'd6:    d[2]  = ~d[2];
        4'd7:    d[3]  = ~d[3];
        4'd9:    d[4]  = ~d[4];
        4'd10:   d[5]  = ~d[5];
        4'd11:   d[6]  = ~d[6];
        4'd12:   d[7]  = ~d[7];
        4'd13:   d[8]  = ~d[8];
        4'd14:   d[9]  = ~d[9];
        4'd15:   d[10] = ~d[10];
        default: d = d;
      endcase
    end else if (syn[3:0] != 4'd0) begin
      dbl = 1'b1;
    end
    return {dbl, 4'b0000, d[10:8], d[7:0]};
  endfunction

endpackage

// File: rtl/top_level_data_mem.sv
// Single-port byte memory: combinational read, synchronous write, never reset.
module data_mem #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] core [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end

  assign rdata = core[addr];

endmodule

// File: rtl/top_level.sv
// Hardwired accelerator: each accepted req runs encode, decode, then pattern count, cyclically.
// Optional CYCLE_COUNT_EN: stores a saturating busy-cycle count in core[195] at the end of each run.
module top_level
  import top_level_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic ack
);

  // Handshake: req is accepted only in S_IDLE; acceptance clears ack, and
  // ack rises together with the final memory write, staying high until the next accepted req.
  state_e      state_q, state_d;
  prog_e       prog_q, prog_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] res_q, res_d;
  logic [4:0]  pat_q, pat_d;
  logic [3:0]  prev_q, prev_d;
  logic [7:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_c_q, cnt_c_d;
  logic        ack_q, ack_d;
`ifdef CYCLE_COUNT_EN
  logic [7:0]  cyc_q, cyc_d;
`endif

  logic        mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  base_in, base_out, word_off;
  logic [11:0] win;
  logic [2:0]  hits_in, hits_x;
  logic        finish, done;

  data_mem #(.DEPTH(MEM_DEPTH)) data_mem1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign base_in  = (prog_q == PROG1) ? P1_IN  : P2_IN;
  assign base_out = (prog_q == PROG1) ? P1_OUT : P2_OUT;
  assign word_off = {2'b00, idx_q, 1'b0} + {7'd0, step_q[0]};
  assign ack      = ack_q;

  // prev_q holds the low nibble of the previous byte so windows spanning a byte boundary are seen.
  always_comb begin
    win     = {prev_q, mem_rdata};
    hits_in = '0;
    hits_x  = '0;
    for (int m = 0; m < 4; m++) begin
      if (win[m +: 5] == pat_q) hits_in = hits_in + 3'd1;
    end
    for (int m = 4; m < 8; m++) begin
      if (win[m +: 5] == pat_q && idx_q != 5'd0) hits_x = hits_x + 3'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    prog_d    = prog_q;
    idx_d     = idx_q;
    step_d    = step_q;
    lo_d      = lo_q;
    res_d     = res_q;
    pat_d     = pat_q;
    prev_d    = prev_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    cnt_c_d   = cnt_c_q;
    ack_d     = ack_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    finish    = 1'b0;
    done      = 1'b0;
`ifdef CYCLE_COUNT_EN
    cyc_d     = (cyc_q != 8'hFF) ? cyc_q + 8'd1 : cyc_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef CYCLE_COUNT_EN
        cyc_d = '0;
`endif
        if (req) begin
          ack_d   = 1'b0;
          idx_d   = '0;
          step_d  = '0;
          prev_d  = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
          cnt_c_d = '0;
          state_d = (prog_q == PROG3) ? S_PAT : S_WORD;
        end
      end
      S_WORD: begin
        case (step_q)
          2'd0: begin
            mem_addr = base_in + word_off;
            lo_d     = mem_rdata;
          end
          2'd1: begin
            mem_addr = base_in + word_off;
            res_d    = (prog_q == PROG1) ? hamming_encode({mem_rdata[2:0], lo_q})
                                         : hamming_decode({mem_rdata, lo_q});
          end
          2'd2: begin
            mem_we    = 1'b1;
            mem_addr  = base_out + word_off;
            mem_wdata = res_q[7:0];
          end
          default: begin
            mem_we    = 1'b1;
            mem_addr  = base_out + word_off;
            mem_wdata = res_q[15:8];
            idx_d     = idx_q + 5'd1;
            finish    = (idx_q == 5'(WORDS - 1));
          end
        endcase
        step_d = step_q + 2'd1;
      end
      S_PAT: begin
        mem_addr = P3_PAT;
        pat_d    = mem_rdata[4:0];
        state_d  = S_SCAN;
      end
      S_SCAN: begin
        mem_addr = P3_STR + {3'b000, idx_q};
        cnt_a_d  = cnt_a_q + {5'd0, hits_in};
        cnt_b_d  = cnt_b_q + {7'd0, (hits_in != 3'd0)};
        cnt_c_d  = cnt_c_q + {5'd0, hits_in} + {5'd0, hits_x};
        prev_d   = mem_rdata[3:0];
        idx_d    = idx_q + 5'd1;
        if (idx_q == 5'(STR_BYTES - 1)) state_d = S_W0;
      end
      S_W0: begin
        mem_we    = 1'b1;
        mem_addr  = P3_OUT;
        mem_wdata = cnt_a_q;
        state_d   = S_W1;
      end
      S_W1: begin
        mem_we    = 1'b1;
        mem_addr  = P3_OUT + 8'd1;
        mem_wdata = cnt_b_q;
        state_d   = S_W2;
      end
      S_W2: begin
        mem_we    = 1'b1;
        mem_addr  = P3_OUT + 8'd2;
        mem_wdata = cnt_c_q;
        finish    = 1'b1;
      end
`ifdef CYCLE_COUNT_EN
      S_CYC: begin
        mem_we    = 1'b1;
        mem_addr  = CYC_OUT;
        mem_wdata = cyc_q;
        done      = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
`ifdef CYCLE_COUNT_EN
      state_d = S_CYC;
`else
      done = 1'b1;
`endif
    end

    if (done) begin
      ack_d   = 1'b1;
      state_d = S_IDLE;
      case (prog_q)
        PROG1:   prog_d = PROG2;
        PROG2:   prog_d = PROG3;
        default: prog_d = PROG1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      prog_q  <= PROG1;
      idx_q   <= '0;
      step_q  <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      pat_q   <= '0;
      prev_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
      ack_q   <= 1'b0;
`ifdef CYCLE_COUNT_EN
      cyc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      pat_q   <= pat_d;
      prev_q  <= prev_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
      ack_q   <= ack_d;
`ifdef CYCLE_COUNT_EN
      cyc_q   <= cyc_d;
`endif
    end
  end

endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for top_level: expected memory bytes are queued per run and checked when ack rises.
`timescale 1ns/1ps
module tb_top_level;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req = 1'b0;
  logic ack;

  top_level #(.MEM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ack   (ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_addr_q[$];
  int exp_n_q[$];
  int pend_n = 0;
  bit ack_prev = 1'b0;

  // Inputs are {hi_byte, lo_byte}; expected outputs are hand-computed.
  logic [15:0] p1_in  [15] = '{16'h0001, 16'h07FF, 16'h0000, 16'hFFFF, 16'h0002, 16'h0400,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000};
  logic [15:0] p1_exp [15] = '{16'h000F, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0033, 16'h8117,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000};
  logic [15:0] p2_in  [15] = '{16'h0007, 16'h000E, 16'h0006, 16'hFFFF, 16'h0000, 16'h0117,
                               16'h8111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000};
  logic [15:0] p2_exp [15] = '{16'h0001, 16'h0001, 16'h8000, 16'h07FF, 16'h0000, 16'h0400,
                               16'h8400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic expect_byte(input logic [7:0] a, input logic [7:0] v);
    exp_addr_q.push_back(a);
    exp_q.push_back(v);
    pend_n++;
  endtask

  task automatic close_run();
    exp_n_q.push_back(pend_n);
    pend_n = 0;
  endtask

  task automatic start_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("ack_clr", {7'd0, ack}, 8'h00);
  endtask

  task automatic wait_ack(input bit poke);
    int cyc;
    cyc = 0;
    while (!ack && cyc < 100) begin
      req = (poke && cyc == 5);
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    total++;
    if (!ack) begin
      bad++;
      $display("FAIL timeout: ack=%0b after %0d cycles, want 1", ack, cyc);
    end else begin
      total++;
      if (cyc > 80) begin
        bad++;
        $display("FAIL latency: got %0d cycles want <=80", cyc);
      end
    end
    @(negedge clk);
  endtask

  // Monitor: each ack rising edge consumes one run's worth of expected bytes.
  always @(negedge clk) begin
    if (ack && !ack_prev) begin
      if (exp_n_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ack: got ack=1 want no completion");
      end else begin
        int n;
        logic [7:0] a, e;
        n = exp_n_q.pop_front();
        for (int k = 0; k < n; k++) begin
          a = exp_addr_q.pop_front();
          e = exp_q.pop_front();
          chk($sformatf("mem[%0d]", a), dut.data_mem1.core[a], e);
        end
      end
    end
    ack_prev = ack;
  end

  initial begin
    for (int i = 0; i < 256; i++) dut.data_mem1.core[i] = 8'h00;
    for (int i = 0; i < 15; i++) begin
      dut.data_mem1.core[2*i]      = p1_in[i][7:0];
      dut.data_mem1.core[2*i + 1]  = p1_in[i][15:8];
      dut.data_mem1.core[64 + 2*i] = p2_in[i][7:0];
      dut.data_mem1.core[65 + 2*i] = p2_in[i][15:8];
    end
    dut.data_mem1.core[60]  = 8'h5A;
    dut.data_mem1.core[124] = 8'hC3;
    dut.data_mem1.core[160] = 8'hE0;
    dut.data_mem1.core[195] = 8'hA5;

    repeat (3) @(negedge clk);
    chk("reset_ack", {7'd0, ack}, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    // Run 1: encode, with a req poked while busy.
    for (int i = 0; i < 15; i++) begin
      expect_byte(8'(30 + 2*i), p1_exp[i][7:0]);
      expect_byte(8'(31 + 2*i), p1_exp[i][15:8]);
    end
    expect_byte(8'd60, 8'h5A);
    close_run();
    start_req();
    wait_ack(1'b1);
    chk("ack_hold", {7'd0, ack}, 8'h01);

    // Run 2: decode; the busy poke must not have advanced the program pointer.
    for (int i = 0; i < 15; i++) begin
      expect_byte(8'(94 + 2*i), p2_exp[i][7:0]);
      expect_byte(8'(95 + 2*i), p2_exp[i][15:8]);
    end
    expect_byte(8'd124, 8'hC3);
    close_run();
    start_req();
    wait_ack(1'b0);

    // Run 3: all-zero string, pattern 0 (upper pattern byte bits ignored).
    expect_byte(8'd192, 8'd128);
    expect_byte(8'd193, 8'd32);
    expect_byte(8'd194, 8'd252);
`ifndef CYCLE_COUNT_EN
    expect_byte(8'd195, 8'hA5);
`endif
    close_run();
    start_req();
    wait_ack(1'b0);

    // Run 4: pointer wraps back to encode.
    dut.data_mem1.core[0] = 8'h02;
    expect_byte(8'd30, 8'h33);
    expect_byte(8'd31, 8'h00);
    close_run();
    start_req();
    wait_ack(1'b0);

    // Run 5: decode aborted by reset mid-run.
    start_req();
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_mid_ack", {7'd0, ack}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    chk("mem_keep_in", dut.data_mem1.core[0], 8'h02);
    chk("mem_keep_out", dut.data_mem1.core[30], 8'h33);
    @(negedge clk);

    // Run 6: after reset the pointer is back at encode.
    dut.data_mem1.core[4] = 8'h00;
    dut.data_mem1.core[5] = 8'h04;
    expect_byte(8'd34, 8'h17);
    expect_byte(8'd35, 8'h81);
    close_run();
    start_req();
    wait_ack(1'b0);

    // Asynchronous reset while idle clears ack before any clock edge.
    #2 reset = 1'b0;
    #1 chk("rst_async_ack", {7'd0, ack}, 8'h00);
    #1 reset = 1'b1;
    @(negedge clk);

    // Run 7: encode again, proving the pointer was reset.
    dut.data_mem1.core[6] = 8'h01;
    dut.data_mem1.core[7] = 8'h00;
    expect_byte(8'd36, 8'h0F);
    expect_byte(8'd37, 8'h00);
    close_run();
    start_req();
    wait_ack(1'b0);

    // Run 8: decode with a new single-error word in slot 7.
    dut.data_mem1.core[78] = 8'h17;
    dut.data_mem1.core[79] = 8'h01;
    expect_byte(8'd108, 8'h00);
    expect_byte(8'd109, 8'h04);
    close_run();
    start_req();
    wait_ack(1'b0);

    // Run 9: alternating string 0x55, pattern 10101.
    for (int i = 128; i < 160; i++) dut.data_mem1.core[i] = 8'h55;
    dut.data_mem1.core[160] = 8'hF5;
    expect_byte(8'd192, 8'd64);
    expect_byte(8'd193, 8'd32);
    expect_byte(8'd194, 8'd126);
    close_run();
    start_req();
    wait_ack(1'b0);

    total++;
    if (exp_n_q.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d runs %0d bytes pending want 0", exp_n_q.size(), exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
